mem_access_unit: RTL and testbench
==================================

Name: mem_access_unit

Overview:
- MEM-stage consumer of the EX/MEM pipeline register outputs.
- Turns the latched store/load controls (MemWrite, MemToReg, Sb, Sh, ExtrWord, ExtrSigned) into a req/ack transaction on the data-memory port.
- Sb/Sh stores produce byte enables and lane replication; loads produce extracted and extended data for the MEM/WB register.
- Drives busy to hold the upstream pipeline registers for the duration of a multi-cycle access.

Parameters:
DATA_BITS, 32, data path width (fixed lane logic assumes 32)
ADDR_BITS, 32, address width
WAIT_MAX, 15, max WAIT cycles before timeout (4-bit counter)

Ports:
clk  input  1  clock, all state updates on rising edge
rst  input  1  synchronous active-high reset
valid_in  input  1  MEM stage holds a valid instruction
addr  input  ADDR_BITS  effective address (EX/MEM result_1_out)
wdata  input  DATA_BITS  store data (EX/MEM EXRegister2Data_out)
MemWrite  input  1  store access
MemToReg  input  1  load access
Sb  input  1  store byte
Sh  input  1  store halfword
ExtrWord  input  2  load width: 00 word, 01 byte, 10 halfword, 11 treated as word
ExtrSigned  input  1  1 sign-extend, 0 zero-extend
mem_ack  input  1  memory completes current request
mem_rdata  input  DATA_BITS  memory read data, valid with mem_ack
mem_req  output  1  request, held until ack or timeout
mem_we  output  1  write request
mem_addr  output  ADDR_BITS  word-aligned address, addr with [1:0] cleared
mem_wdata  output  DATA_BITS  lane-replicated store data
mem_be  output  4  byte enables, bit i = byte lane i (little-endian)
load_data  output  DATA_BITS  extracted/extended load result
done  output  1  one-cycle completion pulse
busy  output  1  hold upstream pipeline
timeout_err  output  1  completion was a timeout
align_err  output  1  misaligned access (see Optional Feature)

Behaviour:
- FSM states: IDLE, WAIT, DONE.
- rst: state=IDLE. mem_req, mem_we, mem_be, done, timeout_err, align_err, load_data, mem_addr, mem_wdata and the counter all = 0.
- Reset mid-WAIT: mem_req is 0 after the reset edge; a late mem_ack is ignored.
- Start condition: valid_in && (MemWrite || MemToReg). If both are set, the store wins.
- IDLE with start:
  - Capture the transaction into registers; go to WAIT.
  - mem_req=1 from the next cycle.
  - busy=1 combinationally in the accept cycle.
- IDLE without start: busy=0. mem_ack is ignored.
- WAIT:
  - mem_req=1 and busy=1.
  - Counter increments each cycle.
  - On mem_ack: latch the load result and go to DONE.
  - If the counter reaches WAIT_MAX with no ack: go to DONE with timeout_err=1 and load_data=0.
  - Ack and timeout in the same cycle: the ack wins.
- DONE:
  - done=1 and busy=0 for exactly one cycle; then go to IDLE.
  - A start in DONE is not accepted; it is accepted in the following IDLE cycle.
- Latency: ack in WAIT cycle N gives done in cycle N+1. A zero-wait memory gives accept at T, req at T+1, done at T+2.
- Stores:
  - Sb: be = 1<<addr[1:0]; wdata[7:0] replicated to 4 lanes.
  - Sh: be = addr[1] ? 1100 : 0011; wdata[15:0] replicated to 2 lanes.
  - Otherwise: be = 1111, wdata passed through.
  - mem_we=1.
- Loads:
  - mem_we=0, be=1111.
  - Byte: lane addr[1:0], extended per ExtrSigned.
  - Half: lane addr[1], extended per ExtrSigned.
  - Word: passed through.
- load_data, timeout_err and align_err hold their values until the next completion; rst clears them.

Optional Feature:
MEM_ALIGN_CHECK_EN
- Defined:
  - Misaligned accesses are detected: half with addr[0]=1, or word (load or non-Sb/Sh store) with addr[1:0]!=0.
  - On accept they skip WAIT: mem_req is never asserted, and the FSM goes directly to DONE with align_err=1.
  - load_data=0.
- Undefined:
  - align_err is tied to 0.
  - Low address bits are ignored for word accesses; the half lane uses addr[1] only.

Test Plan:
- Sb, addr=0x1003, wdata=0x000000AB, ack after 2 WAIT cycles -> mem_be=1000, mem_wdata=0xABABABAB, mem_addr=0x1000, mem_we=1, busy high 3 cycles, done pulse 1 cycle.
- Byte load, ExtrSigned=1, addr=0x2001, mem_rdata=0x1234F000 -> load_data=0xFFFFFFF0.
- Half load, ExtrSigned=0, addr=0x2002, mem_rdata=0x8001ABCD -> load_data=0x00008001.
- No ack for 15 WAIT cycles -> timeout_err=1, load_data=0, done pulse, mem_req drops; a later ack is ignored.
- Assert rst in WAIT cycle 2, then ack -> outputs all 0, state IDLE, no done pulse.
- With MEM_ALIGN_CHECK_EN defined: word load at addr 0x3002 -> mem_req never set, align_err=1 and done in the cycle after accept. Without the macro -> normal access at 0x3000.

Source files
------------

// File: rtl/mem_access_unit.sv
// MEM-stage data-memory access unit: turns EX/MEM store/load controls into a req/ack transaction.
// Optional misaligned-access detection is compiled in with MEM_ALIGN_CHECK_EN.
module mem_access_unit #(
  parameter int DATA_BITS = 32,
  parameter int ADDR_BITS = 32,
  parameter int WAIT_MAX  = 15
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 valid_in,
  input  logic [ADDR_BITS-1:0] addr,
  input  logic [DATA_BITS-1:0] wdata,
  input  logic                 MemWrite,
  input  logic                 MemToReg,
  input  logic                 Sb,
  input  logic                 Sh,
  input  logic [1:0]           ExtrWord,
  input  logic                 ExtrSigned,
  input  logic                 mem_ack,
  input  logic [DATA_BITS-1:0] mem_rdata,
  output logic                 mem_req,
  output logic                 mem_we,
  output logic [ADDR_BITS-1:0] mem_addr,
  output logic [DATA_BITS-1:0] mem_wdata,
  output logic [3:0]           mem_be,
  output logic [DATA_BITS-1:0] load_data,
  output logic                 done,
  output logic                 busy,
  output logic                 timeout_err,
  output logic                 align_err
);

  typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

  // Access width encoding shared by stores and loads: 00 word, 01 byte, 10 half.
  localparam logic [1:0] W_WORD = 2'b00;
  localparam logic [1:0] W_BYTE = 2'b01;
  localparam logic [1:0] W_HALF = 2'b10;

  state_t               state_q, state_d;
  logic [3:0]           cnt_q, cnt_d;
  logic                 we_q, we_d;
  logic [3:0]           be_q, be_d;
  logic [ADDR_BITS-1:0] addr_q, addr_d;
  logic [DATA_BITS-1:0] wdata_q, wdata_d;
  logic [1:0]           width_q, width_d;
  logic                 signed_q, signed_d;
  logic [1:0]           lane_q, lane_d;
  logic [DATA_BITS-1:0] load_data_q, load_data_d;
  logic                 timeout_q, timeout_d;
  logic                 align_q, align_d;

  logic                 start;
  logic                 misaligned;
  logic [1:0]           acc_width;
  logic [7:0]           byte_sel;
  logic [15:0]          half_sel;
  logic [DATA_BITS-1:0] extracted;

  assign start = valid_in && (MemWrite || MemToReg);

  always_comb begin
    if (MemWrite) begin
      acc_width = Sb ? W_BYTE : (Sh ? W_HALF : W_WORD);
    end else begin
      acc_width = (ExtrWord == 2'b11) ? W_WORD : ExtrWord;
    end
  end

`ifdef MEM_ALIGN_CHECK_EN
  assign misaligned = ((acc_width == W_HALF) && addr[0]) ||
                      ((acc_width == W_WORD) && (addr[1:0] != 2'b00));
`else
  assign misaligned = 1'b0;
`endif

  always_comb begin
    case (lane_q)
      2'd0:    byte_sel = mem_rdata[7:0];
      2'd1:    byte_sel = mem_rdata[15:8];
      2'd2:    byte_sel = mem_rdata[23:16];
      default: byte_sel = mem_rdata[31:24];
    endcase
    half_sel = lane_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (width_q)
      W_BYTE:  extracted = {{24{signed_q & byte_sel[7]}}, byte_sel};
      W_HALF:  extracted = {{16{signed_q & half_sel[15]}}, half_sel};
      default: extracted = mem_rdata;
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    we_d        = we_q;
    be_d        = be_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    width_d     = width_q;
    signed_d    = signed_q;
    lane_d      = lane_q;
    load_data_d = load_data_q;
    timeout_d   = timeout_q;
    align_d     = align_q;
    busy        = 1'b0;
    case (state_q)
      IDLE: begin
        if (start) begin
          busy     = 1'b1;
          cnt_d    = '0;
          we_d     = MemWrite;
          addr_d   = {addr[ADDR_BITS-1:2], 2'b00};
          width_d  = acc_width;
          signed_d = ExtrSigned;
          lane_d   = addr[1:0];
          if (MemWrite && Sb) begin
            be_d    = 4'b0001 << addr[1:0];
            wdata_d = {4{wdata[7:0]}};
          end else if (MemWrite && Sh) begin
            be_d    = addr[1] ? 4'b1100 : 4'b0011;
            wdata_d = {2{wdata[15:0]}};
          end else begin
            be_d    = 4'b1111;
            wdata_d = wdata;
          end
          // Misaligned accesses never reach the memory port.
          if (misaligned) begin
            state_d     = DONE;
            align_d     = 1'b1;
            timeout_d   = 1'b0;
            load_data_d = '0;
          end else begin
            state_d = WAIT;
          end
        end
      end
      WAIT: begin
        busy  = 1'b1;
        cnt_d = cnt_q + 4'd1;
        if (mem_ack) begin
          state_d   = DONE;
          timeout_d = 1'b0;
          align_d   = 1'b0;
          if (!we_q) load_data_d = extracted;
        end else if (cnt_d == 4'(WAIT_MAX)) begin
          state_d     = DONE;
          timeout_d   = 1'b1;
          align_d     = 1'b0;
          load_data_d = '0;
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      we_q        <= 1'b0;
      be_q        <= '0;
      addr_q      <= '0;
      wdata_q     <= '0;
      width_q     <= '0;
      signed_q    <= 1'b0;
      lane_q      <= '0;
      load_data_q <= '0;
      timeout_q   <= 1'b0;
      align_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      be_q        <= be_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      width_q     <= width_d;
      signed_q    <= signed_d;
      lane_q      <= lane_d;
      load_data_q <= load_data_d;
      timeout_q   <= timeout_d;
      align_q     <= align_d;
    end
  end

  assign mem_req     = (state_q == WAIT);
  assign done        = (state_q == DONE);
  assign mem_we      = we_q;
  assign mem_be      = be_q;
  assign mem_addr    = addr_q;
  assign mem_wdata   = wdata_q;
  assign load_data   = load_data_q;
  assign timeout_err = timeout_q;
  assign align_err   = align_q;

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit; expected values are hand-computed constants.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        valid_in;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        MemWrite, MemToReg, Sb, Sh;
  logic [1:0]  ExtrWord;
  logic        ExtrSigned;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        mem_req, mem_we;
  logic [31:0] mem_addr, mem_wdata, load_data;
  logic [3:0]  mem_be;
  logic        done, busy, timeout_err, align_err;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_access_unit #(.DATA_BITS(32), .ADDR_BITS(32), .WAIT_MAX(15)) dut (
    .clk(clk), .rst(rst), .valid_in(valid_in), .addr(addr), .wdata(wdata),
    .MemWrite(MemWrite), .MemToReg(MemToReg), .Sb(Sb), .Sh(Sh),
    .ExtrWord(ExtrWord), .ExtrSigned(ExtrSigned), .mem_ack(mem_ack),
    .mem_rdata(mem_rdata), .mem_req(mem_req), .mem_we(mem_we),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .load_data(load_data), .done(done), .busy(busy),
    .timeout_err(timeout_err), .align_err(align_err)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_inputs();
    valid_in = 0; MemWrite = 0; MemToReg = 0; Sb = 0; Sh = 0;
    ExtrWord = 2'b00; ExtrSigned = 0; mem_ack = 0;
  endtask

  task automatic start_store(input logic [31:0] a, input logic [31:0] d, input logic sb, input logic sh);
    valid_in = 1; MemWrite = 1; MemToReg = 0; Sb = sb; Sh = sh; addr = a; wdata = d;
  endtask

  task automatic start_load(input logic [31:0] a, input logic [1:0] w, input logic s);
    valid_in = 1; MemWrite = 0; MemToReg = 1; Sb = 0; Sh = 0; addr = a; ExtrWord = w; ExtrSigned = s;
  endtask

  task automatic test_reset();
    rst = 1; clear_inputs(); addr = '0; wdata = '0; mem_rdata = '0;
    tick(); tick();
    checks++; if ({mem_req, mem_we, mem_be, done, busy, timeout_err, align_err} !== 10'b0) begin
      errors++; $display("FAIL reset_ctrl: got %b want 0", {mem_req, mem_we, mem_be, done, busy, timeout_err, align_err}); end
    checks++; if ({load_data, mem_addr, mem_wdata} !== 96'b0) begin
      errors++; $display("FAIL reset_data: got %h %h %h want 0", load_data, mem_addr, mem_wdata); end
    rst = 0;
    tick();
  endtask

  task automatic test_store_byte();
    int busy_cnt = 0;
    int done_cnt = 0;
    start_store(32'h0000_1003, 32'h0000_00AB, 1, 0);
    #1;
    checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL sb_accept: busy=%b req=%b want busy=1 req=0", busy, mem_req); end
    busy_cnt += int'(busy);
    tick(); clear_inputs();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_be !== 4'b1000) begin
      errors++; $display("FAIL sb_ctrl: req=%b we=%b be=%b want 1 1 1000", mem_req, mem_we, mem_be); end
    checks++; if (mem_wdata !== 32'hABAB_ABAB || mem_addr !== 32'h0000_1000) begin
      errors++; $display("FAIL sb_data: wdata=%h addr=%h want ababab ab/00001000", mem_wdata, mem_addr); end
    busy_cnt += int'(busy); done_cnt += int'(done);
    tick(); mem_ack = 1;
    busy_cnt += int'(busy); done_cnt += int'(done);
    tick(); mem_ack = 0;
    checks++; if (done !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL sb_done: done=%b req=%b want 1 0", done, mem_req); end
    busy_cnt += int'(busy); done_cnt += int'(done);
    for (int i = 0; i < 2; i++) begin
      tick(); busy_cnt += int'(busy); done_cnt += int'(done);
    end
    checks++; if (busy_cnt !== 3 || done_cnt !== 1) begin
      errors++; $display("FAIL sb_pulse_len: busy=%0d done=%0d want 3 1", busy_cnt, done_cnt); end
  endtask

  task automatic test_store_half_word();
    start_store(32'h0000_1002, 32'h1234_CDEF, 0, 1);
    tick(); clear_inputs();
    checks++; if (mem_be !== 4'b1100 || mem_wdata !== 32'hCDEF_CDEF || mem_addr !== 32'h0000_1000) begin
      errors++; $display("FAIL sh_upper: be=%b wdata=%h addr=%h want 1100 cdefcdef 00001000", mem_be, mem_wdata, mem_addr); end
    mem_ack = 1; tick(); mem_ack = 0; tick();
    start_store(32'h0000_1000, 32'h1234_CDEF, 0, 1);
    tick(); clear_inputs();
    checks++; if (mem_be !== 4'b0011 || mem_wdata !== 32'hCDEF_CDEF) begin
      errors++; $display("FAIL sh_lower: be=%b wdata=%h want 0011 cdefcdef", mem_be, mem_wdata); end
    mem_ack = 1; tick(); mem_ack = 0; tick();
    start_store(32'h0000_1008, 32'h1122_3344, 0, 0);
    tick(); clear_inputs();
    checks++; if (mem_be !== 4'b1111 || mem_wdata !== 32'h1122_3344 || mem_addr !== 32'h0000_1008) begin
      errors++; $display("FAIL sw: be=%b wdata=%h addr=%h want 1111 11223344 00001008", mem_be, mem_wdata, mem_addr); end
    mem_ack = 1; tick(); mem_ack = 0; tick();
  endtask

  task automatic test_load_byte_signed();
    start_load(32'h0000_2001, 2'b01, 1);
    tick(); clear_inputs();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b0 || mem_be !== 4'b1111 || mem_addr !== 32'h0000_2000) begin
      errors++; $display("FAIL lb_ctrl: req=%b we=%b be=%b addr=%h want 1 0 1111 00002000", mem_req, mem_we, mem_be, mem_addr); end
    mem_ack = 1; mem_rdata = 32'h1234_F000;
    tick(); mem_ack = 0;
    checks++; if (done !== 1'b1 || load_data !== 32'hFFFF_FFF0 || timeout_err !== 1'b0) begin
      errors++; $display("FAIL lb_result: done=%b data=%h to=%b want 1 fffffff0 0", done, load_data, timeout_err); end
    tick();
  endtask

  task automatic test_load_half_unsigned();
    start_load(32'h0000_2002, 2'b10, 0);
    tick(); clear_inputs();
    mem_ack = 1; mem_rdata = 32'h8001_ABCD;
    tick(); mem_ack = 0;
    checks++; if (done !== 1'b1 || load_data !== 32'h0000_8001) begin
      errors++; $display("FAIL lhu_result: done=%b data=%h want 1 00008001", done, load_data); end
    tick();
    start_load(32'h0000_2000, 2'b10, 1);
    tick(); clear_inputs();
    mem_ack = 1; mem_rdata = 32'h0000_9ABC;
    tick(); mem_ack = 0;
    checks++; if (load_data !== 32'hFFFF_9ABC) begin
      errors++; $display("FAIL lh_signed: data=%h want ffff9abc", load_data); end
    tick();
  endtask

  task automatic test_load_word();
    start_load(32'h0000_2000, 2'b11, 1);
    tick(); clear_inputs();
    mem_ack = 1; mem_rdata = 32'hDEAD_BEEF;
    tick(); mem_ack = 0;
    checks++; if (load_data !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL lw_result: data=%h want deadbeef", load_data); end
    tick();
  endtask

  task automatic test_timeout();
    int req_cnt = 0;
    start_load(32'h0000_4000, 2'b00, 0);
    tick(); clear_inputs();
    for (int i = 0; i < 15; i++) begin
      req_cnt += int'(mem_req);
      tick();
    end
    checks++; if (req_cnt !== 15) begin
      errors++; $display("FAIL to_req_cycles: got %0d want 15", req_cnt); end
    checks++; if (done !== 1'b1 || timeout_err !== 1'b1 || load_data !== 32'h0 || mem_req !== 1'b0) begin
      errors++; $display("FAIL to_done: done=%b to=%b data=%h req=%b want 1 1 0 0", done, timeout_err, load_data, mem_req); end
    mem_ack = 1; mem_rdata = 32'h5555_5555;
    tick();
    tick(); mem_ack = 0;
    checks++; if (done !== 1'b0 || mem_req !== 1'b0 || load_data !== 32'h0 || timeout_err !== 1'b1) begin
      errors++; $display("FAIL to_late_ack: done=%b req=%b data=%h to=%b want 0 0 0 1", done, mem_req, load_data, timeout_err); end
  endtask

  task automatic test_ack_at_limit();
    start_load(32'h0000_4004, 2'b00, 0);
    tick(); clear_inputs();
    for (int i = 0; i < 14; i++) tick();
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    tick(); mem_ack = 0;
    checks++; if (done !== 1'b1 || timeout_err !== 1'b0 || load_data !== 32'h0BAD_F00D) begin
      errors++; $display("FAIL ack_limit: done=%b to=%b data=%h want 1 0 0badf00d", done, timeout_err, load_data); end
    tick();
  endtask

  task automatic test_back_to_back();
    start_load(32'h0000_5000, 2'b00, 0);
    tick();
    mem_ack = 1; mem_rdata = 32'h1357_2468;
    tick(); mem_ack = 0;
    MemWrite = 1; addr = 32'h0000_5004; wdata = 32'h0000_0099;
    #1;
    checks++; if (done !== 1'b1 || busy !== 1'b0 || load_data !== 32'h1357_2468) begin
      errors++; $display("FAIL b2b_done: done=%b busy=%b data=%h want 1 0 13572468", done, busy, load_data); end
    tick();
    checks++; if (busy !== 1'b1 || mem_req !== 1'b0) begin
      errors++; $display("FAIL b2b_accept: busy=%b req=%b want 1 0", busy, mem_req); end
    tick(); clear_inputs();
    checks++; if (mem_req !== 1'b1 || mem_we !== 1'b1 || mem_addr !== 32'h0000_5004 || mem_be !== 4'b1111) begin
      errors++; $display("FAIL b2b_store_wins: req=%b we=%b addr=%h be=%b want 1 1 00005004 1111", mem_req, mem_we, mem_addr, mem_be); end
    mem_ack = 1; tick(); mem_ack = 0; tick();
  endtask

  task automatic test_reset_mid_wait();
    start_store(32'h0000_1003, 32'h0000_00AB, 1, 0);
    tick(); clear_inputs();
    tick();
    rst = 1;
    tick(); rst = 0;
    mem_ack = 1; mem_rdata = 32'hFFFF_FFFF;
    checks++; if ({mem_req, mem_we, mem_be, done, timeout_err, align_err} !== 9'b0 ||
                  {load_data, mem_addr, mem_wdata} !== 96'b0) begin
      errors++; $display("FAIL rst_wait_outputs: ctrl=%b data=%h addr=%h wdata=%h want 0",
                         {mem_req, mem_we, mem_be, done, timeout_err, align_err}, load_data, mem_addr, mem_wdata); end
    tick(); mem_ack = 0;
    checks++; if (done !== 1'b0 || mem_req !== 1'b0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_wait_late_ack: done=%b req=%b busy=%b want 0 0 0", done, mem_req, busy); end
    tick();
  endtask

  task automatic test_align();
    start_load(32'h0000_3002, 2'b00, 0);
    #1;
    checks++; if (busy !== 1'b1) begin
      errors++; $display("FAIL align_accept_busy: got %b want 1", busy); end
    tick(); clear_inputs();
`ifdef MEM_ALIGN_CHECK_EN
    checks++; if (done !== 1'b1 || align_err !== 1'b1 || mem_req !== 1'b0 || load_data !== 32'h0) begin
      errors++; $display("FAIL align_detect: done=%b align=%b req=%b data=%h want 1 1 0 0", done, align_err, mem_req, load_data); end
    tick();
    checks++; if (mem_req !== 1'b0 || done !== 1'b0 || align_err !== 1'b1) begin
      errors++; $display("FAIL align_after: req=%b done=%b align=%b want 0 0 1", mem_req, done, align_err); end
`else
    checks++; if (mem_req !== 1'b1 || mem_addr !== 32'h0000_3000 || align_err !== 1'b0) begin
      errors++; $display("FAIL noalign_access: req=%b addr=%h align=%b want 1 00003000 0", mem_req, mem_addr, align_err); end
    mem_ack = 1; mem_rdata = 32'hCAFE_F00D;
    tick(); mem_ack = 0;
    checks++; if (done !== 1'b1 || load_data !== 32'hCAFE_F00D || align_err !== 1'b0) begin
      errors++; $display("FAIL noalign_result: done=%b data=%h align=%b want 1 cafef00d 0", done, load_data, align_err); end
    tick();
`endif
  endtask

  initial begin
    test_reset();
    test_store_byte();
    test_store_half_word();
    test_load_byte_signed();
    test_load_half_unsigned();
    test_load_word();
    test_timeout();
    test_ack_at_limit();
    test_back_to_back();
    test_reset_mid_wait();
    test_align();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog expired");
  end

endmodule
